wide_adder_seq: RTL and testbench

//   Multi-cycle sequencer that adds two WORDS*32-bit operands with one 32-bit full adder (fulladder32).
//   One word per cycle, LSW first; the carry is registered between words.

---
 rtl/wide_adder_pkg.sv | 12 +
 rtl/fulladder32.sv | 16 +
 rtl/wide_adder_seq.sv | 118 +++++++++++
 tb/tb_wide_adder_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wide_adder_pkg.sv
// Shared constants and types for the word-serial wide adder.
package wide_adder_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } wadd_state_t;

endpackage

// File: rtl/fulladder32.sv
// Single-word full adder; the only arithmetic datapath of the wide adder.
module fulladder32
  import wide_adder_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              carry_i,
  output logic [WORD_W-1:0] sum_o,
  output logic              carry_o
);

  always_comb begin
    {carry_o, sum_o} = (WORD_W+1)'(a_i) + (WORD_W+1)'(b_i) + (WORD_W+1)'(carry_i);
  end

endmodule

// File: rtl/wide_adder_seq.sv
// Word-serial WORDS*32-bit adder: one word per cycle, LSW first, carry
// registered between words, valid/ready handshakes on request and result.
module wide_adder_seq
  import wide_adder_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  output logic                     ready_o,
  input  logic [WORD_W*WORDS-1:0]  a_i,
  input  logic [WORD_W*WORDS-1:0]  b_i,
  input  logic                     carry_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [WORD_W*WORDS-1:0]  sum_o,
  output logic                     carry_o
);

  localparam int unsigned W     = WORD_W * WORDS;
  localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  wadd_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [W-1:0]       a_reg, b_reg;
  logic               carry_q;
  logic [WORD_W-1:0]  a_word, b_word, fa_sum;
  logic               fa_carry;
  logic               last_word;

  assign last_word = (cnt_q == CNT_W'(WORDS - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_i)     state_d = RUN;
      RUN:     if (last_word) state_d = DONE;
      DONE:    if (ready_i)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    unique case (state_q)
      IDLE:    ready_o = 1'b1;
      DONE:    valid_o = 1'b1;
      default: ;
    endcase
  end

  // Counter-selected operand slices feeding the shared adder
  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_word = a_reg[i*WORD_W +: WORD_W];
        b_word = b_reg[i*WORD_W +: WORD_W];
      end
    end
  end

  fulladder32 u_fa (
    .a_i     (a_word),
    .b_i     (b_word),
    .carry_i (carry_q),
    .sum_o   (fa_sum),
    .carry_o (fa_carry)
  );

  // Operand capture and per-word result accumulation
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      carry_q <= 1'b0;
      sum_o   <= '0;
      carry_o <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_i) begin
            a_reg   <= a_i;
            b_reg   <= b_i;
            carry_q <= carry_i;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < WORDS; i++) begin
            if (cnt_q == CNT_W'(i)) sum_o[i*WORD_W +: WORD_W] <= fa_sum;
          end
          carry_q <= fa_carry;
          if (last_word) begin
            carry_o <= fa_carry;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_adder_seq.sv
// Self-checking bench for wide_adder_seq (WORDS=4 and WORDS=1 instances).
module tb_wide_adder_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         req_i = 1'b0;
  logic         ready_i = 1'b1;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic         carry_i = 1'b0;
  logic         ready_o, valid_o, carry_o;
  logic [W-1:0] sum_o;

  logic         req1 = 1'b0;
  logic         ready1_i = 1'b1;
  logic [31:0]  a1 = '0, b1 = '0;
  logic         c1 = 1'b0;
  logic         ready1_o, valid1_o, carry1_o;
  logic [31:0]  sum1_o;

  logic [W:0]   sb_q[$];
  logic [32:0]  sb1_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wide_adder_seq #(.WORDS(WORDS)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .carry_i(carry_i), .valid_o(valid_o),
    .ready_i(ready_i), .sum_o(sum_o), .carry_o(carry_o)
  );

  wide_adder_seq #(.WORDS(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req1), .ready_o(ready1_o),
    .a_i(a1), .b_i(b1), .carry_i(c1), .valid_o(valid1_o),
    .ready_i(ready1_i), .sum_o(sum1_o), .carry_o(carry1_o)
  );

  function automatic logic [W-1:0] rand_w();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drive one request (called at posedge+1), push expectation, return after the accept edge
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    req_i = 1'b1; a_i = a; b_i = b; carry_i = c;
    sb_q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(c));
    @(posedge clk); #1;
    req_i = 1'b0; a_i = rand_w(); b_i = rand_w(); carry_i = $urandom_range(0, 1);
  endtask

  task automatic wait_valid(output int edges);
    edges = -1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (valid_o) begin edges = i; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    n_tests++;
    if ({ready_o, valid_o} !== 2'b10) begin
      n_fail++; $display("FAIL reset_hs: ready/valid=%b required 10", {ready_o, valid_o});
    end
    n_tests++;
    if ({carry_o, sum_o} !== '0) begin
      n_fail++; $display("FAIL reset_sum: got %h required 0", {carry_o, sum_o});
    end
  endtask

  task automatic test_all_ones();
    int e;
    logic [W:0] exp;
    start_op('1, '0, 1'b1);
    wait_valid(e);
    exp = sb_q.pop_front();
    n_tests++;
    if (e !== WORDS) begin n_fail++; $display("FAIL ones_latency: got %0d required %0d", e, WORDS); end
    n_tests++;
    if ({carry_o, sum_o} !== exp || exp !== {1'b1, {W{1'b0}}}) begin
      n_fail++; $display("FAIL ones_sum: got %h required %h", {carry_o, sum_o}, {1'b1, {W{1'b0}}});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({ready_o, valid_o} !== 2'b10) begin
      n_fail++; $display("FAIL ones_after: ready/valid=%b required 10", {ready_o, valid_o});
    end
  endtask

  task automatic test_word_carry();
    int e;
    logic [W:0] exp;
    start_op(W'(64'h0000_0000_FFFF_FFFF), W'(1), 1'b0);
    wait_valid(e);
    exp = sb_q.pop_front();
    n_tests++;
    if ({carry_o, sum_o} !== exp || exp !== (W+1)'(64'h0000_0001_0000_0000)) begin
      n_fail++; $display("FAIL word_carry: got %h required %h", {carry_o, sum_o}, (W+1)'(64'h1_0000_0000));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int e;
    int bad_lat = 0, bad_sum = 0, bad_rdy = 0;
    logic [W:0] exp, got;
    for (int n = 0; n < 100; n++) begin
      if (n % 10 == 0) start_op({32'h1234_5678, 32'h9abc_def0, 32'h0fed_cba9, 32'h8765_4321}, rand_w(), 1'($urandom_range(0, 1)));
      else if (n % 10 == 1) start_op('1, '1, 1'b1);
      else start_op(rand_w(), rand_w(), 1'($urandom_range(0, 1)));
      wait_valid(e);
      exp = sb_q.pop_front();
      got = {carry_o, sum_o};
      n_tests++;
      if (e !== WORDS) begin
        n_fail++; bad_lat++;
        if (bad_lat < 4) $display("FAIL b2b_latency[%0d]: got %0d required %0d", n, e, WORDS);
      end
      n_tests++;
      if (got !== exp) begin
        n_fail++; bad_sum++;
        if (bad_sum < 4) $display("FAIL b2b_sum[%0d]: got %h required %h", n, got, exp);
      end
      @(posedge clk); #1;
      n_tests++;
      if (ready_o !== 1'b1) begin
        n_fail++; bad_rdy++;
        if (bad_rdy < 4) $display("FAIL b2b_ready[%0d]: got %b required 1", n, ready_o);
      end
    end
  endtask

  task automatic test_stall();
    int e;
    logic [W:0] exp;
    ready_i = 1'b0;
    start_op(rand_w(), rand_w(), 1'b1);
    wait_valid(e);
    exp = sb_q.pop_front();
    n_tests++;
    if (e !== WORDS) begin n_fail++; $display("FAIL stall_latency: got %0d required %0d", e, WORDS); end
    for (int i = 0; i < 5; i++) begin
      req_i = 1'b1; a_i = rand_w(); b_i = rand_w();
      @(posedge clk); #1;
      n_tests++;
      if ({valid_o, ready_o} !== 2'b10) begin
        n_fail++; $display("FAIL stall_hs[%0d]: valid/ready=%b required 10", i, {valid_o, ready_o});
      end
      n_tests++;
      if ({carry_o, sum_o} !== exp) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h required %h", i, {carry_o, sum_o}, exp);
      end
    end
    req_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({ready_o, valid_o} !== 2'b10) begin
      n_fail++; $display("FAIL stall_release: ready/valid=%b required 10", {ready_o, valid_o});
    end
    @(posedge clk); #1;
    n_tests++;
    if (ready_o !== 1'b1) begin
      n_fail++; $display("FAIL stall_req_ignored: ready=%b required 1", ready_o);
    end
  endtask

  task automatic test_reset_mid_run();
    int e;
    logic [W:0] exp;
    start_op(rand_w(), rand_w(), 1'b1);
    void'(sb_q.pop_front());
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    n_tests++;
    if ({ready_o, valid_o} !== 2'b10) begin
      n_fail++; $display("FAIL midrst_hs: ready/valid=%b required 10", {ready_o, valid_o});
    end
    n_tests++;
    if ({carry_o, sum_o} !== '0) begin
      n_fail++; $display("FAIL midrst_sum: got %h required 0", {carry_o, sum_o});
    end
    start_op(rand_w(), rand_w(), 1'b0);
    wait_valid(e);
    exp = sb_q.pop_front();
    n_tests++;
    if (e !== WORDS || {carry_o, sum_o} !== exp) begin
      n_fail++; $display("FAIL midrst_newop: lat %0d sum %h required lat %0d sum %h", e, {carry_o, sum_o}, WORDS, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_words1();
    int e;
    logic [32:0] exp;
    for (int n = 0; n < 4; n++) begin
      req1 = 1'b1;
      if (n == 0) begin a1 = 32'hFFFF_FFFF; b1 = 32'h1; c1 = 1'b0; end
      else begin a1 = $urandom(); b1 = $urandom(); c1 = 1'($urandom_range(0, 1)); end
      sb1_q.push_back({1'b0, a1} + {1'b0, b1} + 33'(c1));
      @(posedge clk); #1;
      req1 = 1'b0; a1 = $urandom(); b1 = $urandom();
      e = -1;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk); #1;
        if (valid1_o) begin e = i; break; end
      end
      exp = sb1_q.pop_front();
      n_tests++;
      if (e !== 1) begin n_fail++; $display("FAIL w1_latency[%0d]: got %0d required 1", n, e); end
      n_tests++;
      if ({carry1_o, sum1_o} !== exp || (n == 0 && exp !== 33'h1_0000_0000)) begin
        n_fail++; $display("FAIL w1_sum[%0d]: got %h required %h", n, {carry1_o, sum1_o}, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_word_carry();
    test_back_to_back();
    test_stall();
    test_reset_mid_run();
    test_words1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
